// File: rtl/pkt_mem_reader_if.sv
// rtl/pkt_mem_reader_if.sv - descriptor, SRAM read port and byte stream bundle for pkt_mem_reader
interface pkt_mem_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
);
  logic              i_desc_valid;
  logic              o_desc_ready;
  logic [ADDR_W-1:0] i_desc_addr;
  logic [LEN_W-1:0]  i_desc_len;
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_last;
  logic              i_ready;
  logic              o_busy;

  // reader side
  modport master (
    input  i_desc_valid, i_desc_addr, i_desc_len, i_mem_data, i_ready,
    output o_desc_ready, o_mem_rd, o_mem_addr, o_valid, o_data, o_last, o_busy
  );

  // descriptor source, SRAM and downstream consumer side
  modport slave (
    output i_desc_valid, i_desc_addr, i_desc_len, i_mem_data, i_ready,
    input  o_desc_ready, o_mem_rd, o_mem_addr, o_valid, o_data, o_last, o_busy
  );
endinterface

// File: rtl/pkt_mem_reader.sv
// rtl/pkt_mem_reader.sv - packet SRAM read engine streaming descriptor bytes with last marking
module pkt_mem_reader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = 12
) (
  input logic           i_clk,
  input logic           i_rst_n,
  pkt_mem_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  rd_cnt;
  logic              rd_last;

  logic [DATA_W-1:0] fifo_data0, fifo_data1;
  logic              fifo_last0, fifo_last1;
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;

  logic              accept, push, pop, issue, head_last;
  logic [LEN_W-1:0]  len_clamped;
  logic [ADDR_W-1:0] addr_next;

  assign accept      = bus.i_desc_valid && (state == IDLE);
  assign len_clamped = (bus.i_desc_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.i_desc_len;
  assign addr_next   = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);

  // The read issued last cycle lands in the FIFO on this edge.
  assign push = bus.o_mem_rd;
  assign pop  = (count != 2'd0) && bus.i_ready;

  // A pop in this cycle frees a slot, which keeps the stream gap-free at one byte per cycle.
  assign issue = (state == READ) &&
                 (({1'b0, count} + {2'b0, bus.o_mem_rd}) < (3'd2 + {2'b0, pop}));

  assign head_last        = rd_ptr ? fifo_last1 : fifo_last0;
  assign bus.o_valid      = (count != 2'd0);
  assign bus.o_data       = rd_ptr ? fifo_data1 : fifo_data0;
  assign bus.o_last       = bus.o_valid && head_last;
  assign bus.o_desc_ready = (state == IDLE);
  assign bus.o_busy       = (state != IDLE);

  // Control FSM: descriptor capture, read issue with address wrap, and completion on the last pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      addr           <= '0;
      rd_cnt         <= '0;
      rd_last        <= 1'b0;
      bus.o_mem_rd   <= 1'b0;
      bus.o_mem_addr <= '0;
    end else begin
      bus.o_mem_rd <= issue;
      rd_last      <= issue && (rd_cnt == LEN_W'(1));
      if (issue) begin
        bus.o_mem_addr <= addr;
        addr           <= addr_next;
        rd_cnt         <= rd_cnt - LEN_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept && (len_clamped != '0)) begin
            state  <= READ;
            addr   <= bus.i_desc_addr;
            rd_cnt <= len_clamped;
          end
        end
        READ: begin
          if (issue && (rd_cnt == LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && head_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output FIFO holding each byte with its end-of-packet flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_data0 <= '0;
      fifo_data1 <= '0;
      fifo_last0 <= 1'b0;
      fifo_last1 <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) begin
          fifo_data1 <= bus.i_mem_data;
          fifo_last1 <= rd_last;
        end else begin
          fifo_data0 <= bus.i_mem_data;
          fifo_last0 <= rd_last;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_pkt_mem_reader.sv
// tb/tb_pkt_mem_reader.sv - directed self-checking bench for pkt_mem_reader
module tb_pkt_mem_reader;
  localparam int DEPTH = 3072;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_mem_reader_if #(.DATA_W(8), .ADDR_W(12), .LEN_W(12)) bus_if ();

  pkt_mem_reader #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(12), .LEN_W(12)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus_if)
  );

  // SRAM model: data follows the registered read address
  logic [7:0] mem [DEPTH];
  assign bus_if.i_mem_data = mem[bus_if.o_mem_addr];

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [8:0] exp_q [$];
  int         addr_q [$];
  int         tb_cnt = 0;
  bit         mon_en = 0;
  int         pop_n = 0;
  int         first_pop = 0;
  int         last_pop = 0;
  int         cyc = 0;
  logic       stalled = 1'b0;
  logic [8:0] stall_val = '0;
  logic [7:0] ready_pat = 8'hFF;
  int         rcyc = 0;
  logic       mon_pop;
  logic [8:0] mon_e;

  always @(posedge clk) cyc++;

  // downstream ready follows a repeating 8-cycle pattern, changed just after each edge
  initial begin
    bus_if.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_if.i_ready = ready_pat[rcyc % 8];
      rcyc++;
    end
  end

  // scoreboard: reads, pops, occupancy and stall stability, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      mon_pop = bus_if.o_valid && bus_if.i_ready;
      check("occupancy_le2", 32'((tb_cnt + int'(bus_if.o_mem_rd)) <= 2), 32'd1);
      check("valid_vs_model", 32'(bus_if.o_valid), 32'(tb_cnt != 0));
      if (stalled && bus_if.o_valid)
        check("stall_stable", 32'({bus_if.o_last, bus_if.o_data}), 32'(stall_val));
      if (mon_pop) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("data", 32'(bus_if.o_data), 32'(mon_e[7:0]));
          check("last", 32'(bus_if.o_last), 32'(mon_e[8]));
        end
        if (pop_n == 0) first_pop = cyc;
        last_pop = cyc;
        pop_n++;
      end
      if (bus_if.o_mem_rd) begin
        if (addr_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else check("rd_addr", 32'(bus_if.o_mem_addr), 32'(addr_q.pop_front()));
      end
      stalled   = bus_if.o_valid && !bus_if.i_ready;
      stall_val = {bus_if.o_last, bus_if.o_data};
      tb_cnt    = tb_cnt + int'(bus_if.o_mem_rd) - int'(mon_pop);
    end
  end

  task automatic send_desc(input int a, input int len);
    int  n;
    bit  done;
    n = (len > DEPTH) ? DEPTH : len;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), mem[(a + k) % DEPTH]});
      addr_q.push_back((a + k) % DEPTH);
    end
    @(negedge clk);
    bus_if.i_desc_valid = 1'b1;
    bus_if.i_desc_addr  = 12'(a);
    bus_if.i_desc_len   = 12'(len);
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (bus_if.o_desc_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("desc_accept_timeout", 32'd0, 32'd1);
    bus_if.i_desc_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done;
    done = 0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !bus_if.o_busy && bus_if.o_desc_ready) done = 1;
    end
    check("done_timeout", 32'(done), 32'd1);
    check("reads_consumed", 32'(addr_q.size()), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_desc_ready"}, 32'(bus_if.o_desc_ready), 32'd1);
    check({tag, "_mem_rd"}, 32'(bus_if.o_mem_rd), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus_if.o_mem_addr), 32'd0);
    check({tag, "_valid"}, 32'(bus_if.o_valid), 32'd0);
    check({tag, "_data"}, 32'(bus_if.o_data), 32'd0);
    check({tag, "_last"}, 32'(bus_if.o_last), 32'd0);
    check({tag, "_busy"}, 32'(bus_if.o_busy), 32'd0);
  endtask

  initial begin
    bit got2;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37 + 11) % 256);
    mem[19] = 8'hFF; mem[20] = 8'h03; mem[21] = 8'h0F; mem[22] = 8'h00;
    mem[3070] = 8'hA1; mem[3071] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
    mem[100] = 8'h10; mem[101] = 8'h11; mem[102] = 8'h12;
    mem[200] = 8'h20; mem[201] = 8'h21;
    bus_if.i_desc_valid = 1'b0;
    bus_if.i_desc_addr  = '0;
    bus_if.i_desc_len   = '0;

    // reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    mon_en = 1;

    // 1: basic packet, latency, throughput
    pop_n = 0;
    send_desc(19, 4);
    check("t1_busy_n", 32'(bus_if.o_busy), 32'd1);
    check("t1_ready_n", 32'(bus_if.o_desc_ready), 32'd0);
    check("t1_rd_n", 32'(bus_if.o_mem_rd), 32'd0);
    @(posedge clk); #1;
    check("t1_rd_n1", 32'(bus_if.o_mem_rd), 32'd1);
    check("t1_addr_n1", 32'(bus_if.o_mem_addr), 32'd19);
    check("t1_valid_n1", 32'(bus_if.o_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_n2", 32'(bus_if.o_valid), 32'd1);
    check("t1_data_n2", 32'(bus_if.o_data), 32'hFF);
    wait_done();
    check("t1_pops", 32'(pop_n), 32'd4);
    check("t1_no_bubble", 32'(last_pop - first_pop), 32'd3);

    // 2: address wrap
    pop_n = 0;
    send_desc(3070, 4);
    wait_done();
    check("t2_pops", 32'(pop_n), 32'd4);

    // 3: backpressure
    pop_n = 0;
    rcyc = 0;
    ready_pat = 8'b0110_1001;
    send_desc(50, 5);
    wait_done();
    check("t3_pops", 32'(pop_n), 32'd5);
    ready_pat = 8'hFF;

    // 4: zero-length descriptor
    pop_n = 0;
    send_desc(500, 0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("t4_rd", 32'(bus_if.o_mem_rd), 32'd0);
      check("t4_valid", 32'(bus_if.o_valid), 32'd0);
      check("t4_ready", 32'(bus_if.o_desc_ready), 32'd1);
    end
    check("t4_pops", 32'(pop_n), 32'd0);

    // 5: back-to-back descriptors
    pop_n = 0;
    send_desc(100, 3);
    send_desc(200, 2);
    wait_done();
    check("t5_pops", 32'(pop_n), 32'd5);

    // 6: reset mid-packet, then a clean packet
    pop_n = 0;
    send_desc(300, 8);
    got2 = 0;
    for (int t = 0; t < 100 && !got2; t++) begin
      @(negedge clk);
      #1;
      if (pop_n == 2) got2 = 1;
    end
    check("t6_two_pops", 32'(got2), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mon_en = 0;
    #1;
    check_idle_outputs("t6_async");
    exp_q.delete();
    addr_q.delete();
    tb_cnt = 0;
    stalled = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    pop_n = 0;
    send_desc(400, 3);
    wait_done();
    check("t6_pops_after", 32'(pop_n), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
